// File: rtl/am_ddc.sv
// am_ddc - digital down-converter for the 1-bit AM receiver.
//
// The 1-bit RF comparator stream is mixed with a quadrature square-wave NCO.
// Each product is decimated by R = 2**DECIM_LOG2 through a 3rd-order CIC
// filter. The result is scaled by the configured gain shift and saturated to
// 16-bit signed baseband samples.
//
// Ports:
//   CLK        system clock, all logic on the rising edge
//   RSTb       synchronous active-low reset
//   RF_IN      asynchronous 1-bit RF sample (1 = +1, 0 = -1)
//   phase_inc  NCO phase increment, latched only at the decimation boundary
//   gain       output gain shift 0..7, latched only at the decimation boundary
//   I_out      signed in-phase baseband sample
//   Q_out      signed quadrature baseband sample
//   out_valid  one-cycle pulse marking new I_out/Q_out
module am_ddc #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               RF_IN,
  input  logic [19:0]        phase_inc,
  input  logic [2:0]         gain,
  output logic signed [15:0] I_out,
  output logic signed [15:0] Q_out,
  output logic               out_valid
);

  localparam int W  = 2 + 3 * DECIM_LOG2;  // CIC register width
  localparam int GW = W + 7;               // width after the gain shift
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

  logic                  sync1;
  logic                  rf_s;
  logic [19:0]           acc;
  logic [19:0]           phase_inc_l;
  logic [2:0]            gain_l;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  dec_go;
  logic                  boundary;
  logic                  lo_i;
  logic                  lo_q;
  logic [1:0]            mix;        // [0] = I product, [1] = Q product
  logic [1:0][15:0]      sat_out;    // [0] = I, [1] = Q

  assign boundary = (cnt == CNT_LAST);
  assign lo_i     = ~(acc[19] ^ acc[18]);
  assign lo_q     = ~acc[19];
  assign mix[0]   = ~(rf_s ^ lo_i);
  assign mix[1]   = ~(rf_s ^ lo_q);

  // Synchronizer, NCO, decimation counter, config latch and output registers.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      sync1       <= 1'b0;
      rf_s        <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      phase_inc_l <= 20'h07380;
      gain_l      <= 3'd5;
      dec_go      <= 1'b0;
      out_valid   <= 1'b0;
      I_out       <= '0;
      Q_out       <= '0;
    end else begin
      sync1     <= RF_IN;
      rf_s      <= sync1;
      // The boundary edge still advances with the old increment; the newly
      // latched value is used from the following edge on.
      acc       <= acc + phase_inc_l;
      cnt       <= cnt + 1'b1;       // wraps naturally from R-1 to 0
      dec_go    <= boundary;
      out_valid <= dec_go;
      if (boundary) begin
        phase_inc_l <= phase_inc;
        gain_l      <= gain;
      end
      if (dec_go) begin
        I_out <= sat_out[0];
        Q_out <= sat_out[1];
      end
    end
  end

  // One identical CIC + scaler per channel.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [W-1:0]           x;
    logic [W-1:0]           int1, int2, int3;
    logic [W-1:0]           dec;
    logic [W-1:0]           d1, d2, d3;
    logic [W-1:0]           c1, c2, c3;
    logic [GW-1:0]          g_ext;
    logic signed [GW-1:0]   g;
    logic signed [GW-1:0]   s;
    logic [15:0]            s_sat;

    // +1 is 0...01, -1 is 1...11: only the upper bits depend on the product.
    assign x = {{(W-1){~mix[gi]}}, 1'b1};

    always_ff @(posedge CLK) begin
      if (!RSTb) begin
        int1 <= '0;
        int2 <= '0;
        int3 <= '0;
        dec  <= '0;
        d1   <= '0;
        d2   <= '0;
        d3   <= '0;
      end else begin
        int1 <= int1 + x;
        int2 <= int2 + int1;
        int3 <= int3 + int2;
        if (boundary) begin
          dec <= int3;
        end
        if (dec_go) begin
          d1 <= dec;
          d2 <= c1;
          d3 <= c2;
        end
      end
    end

    always_comb begin
      c1    = dec - d1;
      c2    = c1 - d2;
      c3    = c2 - d3;
      g_ext = {{(GW-W){c3[W-1]}}, c3};
      g     = g_ext << gain_l;
      s     = g >>> (W - 16);
      // In range when every bit from 15 upward equals the sign bit.
      if ((&s[GW-1:15]) || !(|s[GW-1:15])) begin
        s_sat = s[15:0];
      end else if (s[GW-1]) begin
        s_sat = 16'h8000;
      end else begin
        s_sat = 16'h7FFF;
      end
    end

    assign sat_out[gi] = s_sat;
  end

endmodule

// File: doc/am_ddc.md
# am_ddc

Digital down-converter for the 1-bit AM receiver. Sits directly downstream of the SPI configuration block and consumes its `phase_inc` and `gain` outputs. It takes the 1-bit RF comparator stream and mixes it with a quadrature square-wave NCO. It then decimates I and Q through 3rd-order CIC filters and applies the configured gain. The result is 16-bit baseband samples for the envelope detector.

## Interface
- `DECIM_LOG2`, default 6: log2 of the decimation ratio R (R = 64). CIC width W = 2 + 3*DECIM_LOG2 (20).
- `CLK` input 1: system clock; all logic on the rising edge.
- `RSTb` input 1: reset, synchronous, active-low.
- `RF_IN` input 1: asynchronous 1-bit RF sample. 1 represents +1, 0 represents -1.
- `phase_inc` input 20: NCO phase increment from the SPI block. May change at any time, including bit-by-bit during SPI shifting.
- `gain` input 3: output gain shift (0..7) from the SPI block.
- `I_out` output 16: signed in-phase baseband sample.
- `Q_out` output 16: signed quadrature baseband sample.
- `out_valid` output 1: one-cycle pulse marking new `I_out`/`Q_out`.

## Operation
- **Input sync:** `RF_IN` passes through a 2-flop synchronizer; `rf_s` is the second flop.
- **Config latch:** `phase_inc_l` and `gain_l` load from the inputs only at the decimation boundary edge (`cnt == R-1`). Between boundaries the block ignores input changes.
- **NCO:** 20-bit `acc` is updated every cycle as `acc <= acc + phase_inc_l`, modulo 2^20.
  - `lo_i = ~(acc[19] ^ acc[18])` (cos sign).
  - `lo_q = ~acc[19]` (sin sign).
- **Mixer:** `m_i = ~(rf_s ^ lo_i)` and `m_q = ~(rf_s ^ lo_q)`. Each bit maps to a 2-bit signed value: 1 gives +1, 0 gives -1.
- **Integrators:** 3 cascaded W-bit integrators per channel, updated every cycle, wrapping modulo 2^W with no saturation.
- **Decimation counter:**
  - `cnt` is DECIM_LOG2 bits and counts 0..R-1, then wraps to 0.
  - At the boundary edge, integrator 3 is captured into `dec_i`/`dec_q`.
  - At the same edge, `cnt` wraps and the config is latched.
  - A flag `dec_go` is set for exactly one cycle.
- **Comb stage (cycle with `dec_go=1`):**
  - 3 cascaded differentiators, each with differential delay 1, all W-bit modular.
  - Delay registers update at the edge ending this cycle.
- **Scaling:**
  - `g = sign_extend(comb_out, W+7) << gain_l`.
  - `s = g >>> (W-16)` (arithmetic shift, truncates toward minus infinity).
  - Saturate `s` to [-32768, 32767].
- **Output registers:** `I_out`/`Q_out` load the saturated values at the edge ending the `dec_go` cycle. `out_valid` goes to 1 at that same edge and clears at the next edge.
- **DC gain:** CIC gain is R^3 = 2^18. A constant +1 input settles to comb_out = +262144 after 3 output samples.

## Timing
- **Reset values** (any edge with `RSTb=0`, mid-operation included; takes effect at that edge):
  - Sync flops, `acc`, `cnt`, integrators, `dec_*`, comb delays, `I_out`, `Q_out` = 0; `out_valid` = 0; `dec_go` = 0.
  - `phase_inc_l` = 20'h07380 and `gain_l` = 3'd5, matching the SPI block's reset config.
- **Output cadence:**
  - After `RSTb` rises, the 64th edge is the first boundary edge.
  - `out_valid` is first high after the 65th edge.
  - Thereafter `out_valid` pulses every R cycles, never two consecutive cycles.
- **Latency:**
  - `RF_IN` reaches the integrators 2 edges later via the synchronizer.
  - Output appears 1 edge after the boundary capture.
- **Config change:** the new `phase_inc` affects `acc` starting the cycle after the boundary edge. A `gain` change affects the output produced right after that boundary.
- **Simultaneous events:** reset dominates all. A config input change on the boundary edge itself is latched with its new value.

## Test plan
- **Reset/cadence:** hold RSTb=0 for 5 cycles, then release. Required: outputs = 0 and `out_valid` = 0 during reset. First `out_valid` pulse after edge 65, then every 64 cycles, width 1 cycle.
- **DC, phase_inc=0, RF_IN=1, gain=0:**
  - After the 3rd pulse, `I_out` = `Q_out` = 16384.
  - Set gain=1: the next valid output after the latch boundary is 32767 (saturated).
  - RF_IN=0, gain=0: -16384.
- **Quarter-rate LO, phase_inc=20'h40000, RF_IN=1:** lo_i pattern is 1,0,0,1 and lo_q is 1,1,0,0. After settling, `I_out` = `Q_out` = 0 on every pulse.
- **Mid-frame config change:** change `phase_inc` 32 cycles into a frame. Required: `acc` increment stays at the old value until the boundary edge and switches on the following cycle.
- **Reset mid-operation:** pulse RSTb=0 for 1 cycle at frame position 40 with RF_IN=1. Required:
  - All state returns to reset values.
  - `phase_inc_l` = 0x07380, `gain_l` = 5.
  - Next pulse arrives 65 edges after release.
- **Wrap-around:** RF_IN=1, phase_inc=0, gain=0 for 200000 cycles. Required: `I_out` stays at 16384 on every pulse after settling, confirming correct modular integrator behaviour.
